multi_shift_ctrl: RTL and testbench

MULTI_SHIFT_CTRL -- requirements
Module: multi_shift_ctrl

---
 rtl/multi_shift_pkg.sv | 20 ++
 rtl/multi_shift_ctrl_logic_shift.sv | 21 ++
 rtl/multi_shift_ctrl.sv | 97 +++++++++
 tb/tb_multi_shift_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/multi_shift_pkg.sv
// Shared op/state encodings and carry helper for the multi-step shift controller.
package multi_shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Right-moving ops (SRL/ROR) lose bit 0; left-moving ops lose bit 7.
  function automatic logic shifted_out(input logic [7:0] d, input logic [1:0] op);
    return op[0] ? d[0] : d[7];
  endfunction

endpackage

// File: rtl/multi_shift_ctrl_logic_shift.sv
// Single-bit shift/rotate step: one combinational stage fed back by the controller.
module logic_shift
  import multi_shift_pkg::*;
(
  input  logic [7:0] di,
  input  logic [1:0] sel,
  output logic [7:0] so
);

  always_comb begin
    so = di;
    case (sel)
      OP_SLL:  so = {di[6:0], 1'b0};
      OP_SRL:  so = {1'b0, di[7:1]};
      OP_ROL:  so = {di[6:0], di[7]};
      OP_ROR:  so = {di[0], di[7:1]};
      default: so = di;
    endcase
  end

endmodule

// File: rtl/multi_shift_ctrl.sv
// Iterative shifter: accepts a byte/op/count, steps one bit per cycle, holds result until taken.
// Optional carry output enabled by defining SHIFT_CARRY_EN.
module multi_shift_ctrl
  import multi_shift_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [1:0]       in_op,
  input  logic [CNT_W-1:0] in_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy
`ifdef SHIFT_CARRY_EN
  ,
  output logic             carry
`endif
);

  state_t           state;
  logic [7:0]       data_q;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       step_data;

  logic_shift u_step (
    .di  (data_q),
    .sel (op_q),
    .so  (step_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      data_q    <= '0;
      op_q      <= OP_SLL;
      cnt_q     <= '0;
`ifdef SHIFT_CARRY_EN
      carry     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data_q   <= in_data;
            op_q     <= in_op;
            cnt_q    <= in_cnt;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef SHIFT_CARRY_EN
            carry    <= 1'b0;
`endif
            // Zero count skips SHIFT so the result appears one cycle after accept.
            if (in_cnt == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= in_data;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q <= step_data;
          cnt_q  <= cnt_q - CNT_W'(1);
`ifdef SHIFT_CARRY_EN
          carry  <= shifted_out(data_q, op_q);
`endif
          if (cnt_q == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= step_data;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_shift_ctrl.sv
// Directed, table-driven bench for multi_shift_ctrl (carry checked when SHIFT_CARRY_EN is defined).
module tb_multi_shift_ctrl;

  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic [1:0]       in_op;
  logic [CNT_W-1:0] in_cnt;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             busy;
`ifdef SHIFT_CARRY_EN
  logic             carry;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  multi_shift_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_cnt    (in_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef SHIFT_CARRY_EN
    ,
    .carry     (carry)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] op;
    logic [2:0] cnt;
    logic [7:0] exp_data;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one request at a negedge, wait for the result, check latency/value, then take it.
  task automatic run_req(input logic [7:0] d, input logic [1:0] op, input logic [2:0] cnt,
                         input logic [7:0] exp_d, input logic exp_c);
    int waited;
    bit seen;
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    in_cnt   = cnt;
    out_ready = 1'b0;
    waited = 0;
    seen   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      check("in_ready_while_shift", 32'(in_ready), 32'd0);
      waited++;
      @(negedge clk);
    end
    check("result_seen", 32'(seen), 32'd1);
    check("latency", 32'(waited), 32'(cnt));
    check("out_data", 32'(out_data), 32'(exp_d));
    check("in_ready_when_taken", 32'(in_ready), 32'd0);
`ifdef SHIFT_CARRY_EN
    check("carry", 32'(carry), 32'(exp_c));
`else
    if (exp_c === 1'bx) $display("unexpected X carry expectation");
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_take", 32'(out_valid), 32'd0);
    check("in_ready_after_take", 32'(in_ready), 32'd1);
    check("busy_after_take", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'h81, 2'b00, 3'd1, 8'h02, 1'b1};
    vecs[1] = '{8'hF0, 2'b01, 3'd3, 8'h1E, 1'b0};
    vecs[2] = '{8'h96, 2'b10, 3'd4, 8'h69, 1'b1};
    vecs[3] = '{8'h01, 2'b11, 3'd1, 8'h80, 1'b1};
    vecs[4] = '{8'h5A, 2'b00, 3'd0, 8'h5A, 1'b0};
    vecs[5] = '{8'hFF, 2'b00, 3'd7, 8'h80, 1'b1};
    vecs[6] = '{8'h80, 2'b01, 3'd7, 8'h01, 1'b0};
    vecs[7] = '{8'h81, 2'b10, 3'd7, 8'hC0, 1'b0};
    vecs[8] = '{8'h96, 2'b11, 3'd7, 8'h2D, 1'b0};
    vecs[9] = '{8'h01, 2'b01, 3'd1, 8'h00, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_op = '0;
    in_cnt = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
`ifdef SHIFT_CARRY_EN
    check("rst_carry", 32'(carry), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 10; v++)
      run_req(vecs[v].data, vecs[v].op, vecs[v].cnt, vecs[v].exp_data, vecs[v].exp_carry);

    // Backpressure: result held for 5 cycles while new requests are offered and ignored.
    in_valid = 1'b1; in_data = 8'hF0; in_op = 2'b01; in_cnt = 3'd3;
    @(negedge clk);
    in_data = 8'h33; in_op = 2'b00; in_cnt = 3'd2;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'h1E);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_drained", 32'(out_valid), 32'd0);
    repeat (4) @(negedge clk);
    check("bp_no_ghost", 32'(out_valid), 32'd0);
    check("bp_idle", 32'(in_ready), 32'd1);

    // out_ready with no result pending must not disturb anything.
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stray_ready_idle", 32'(in_ready), 32'd1);

    // Reset in the middle of a 7-step shift discards the request.
    in_valid = 1'b1; in_data = 8'hFF; in_op = 2'b00; in_cnt = 3'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'h00);
    repeat (8) begin
      @(negedge clk);
      check("mid_rst_discarded", 32'(out_valid), 32'd0);
    end
    run_req(8'h96, 2'b10, 3'd4, 8'h69, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
